// File: rtl/mult_arb_pkg.sv
// Shared types for the shared-multiplier arbiter.
// Holds the transaction state encoding and its width.
package mult_arb_pkg;

   localparam int MultArbStateWidth = 2;

   typedef enum logic [MultArbStateWidth-1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } mult_arb_state_e;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
// Ports: req (requests), ptr (search start), idx/gnt (winner), any (some req).
module rr_arbiter #(
   parameter int NUM_PORTS = 6,
   parameter int SEL_WIDTH = 3
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [SEL_WIDTH-1:0] ptr,
   output logic [SEL_WIDTH-1:0] idx,
   output logic [NUM_PORTS-1:0] gnt,
   output logic                 any
);

   always_comb begin : pick
      int pos;
      pos = 0;
      idx = '0;
      gnt = '0;
      any = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         // Walk upward from ptr, wrapping past the last port.
         pos = int'(ptr) + i;
         if (pos >= NUM_PORTS) begin
            pos = pos - NUM_PORTS;
         end
         if (!any && req[pos]) begin
            any      = 1'b1;
            idx      = SEL_WIDTH'(pos);
            gnt[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin owner of one sequential multiplier shared by NUM_PORTS ports.
// Latches the winner's operands, pulses start, waits for done, returns result.
// Ports: clk_i/rst_i (async high), req_i/mult_a_i/mult_b_i (requesters),
//   gnt_o/sel_o/result_o/overflow_o/result_valid_o/error_o (responses),
//   mult_a_o/mult_b_o/start_o and value_i/overflow_i/done_i (multiplier).
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort a hung WAIT.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_PORTS     = 6,
   parameter int SEL_WIDTH     = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1,
   parameter int DataWidth     = 8,
   parameter int ResultWidth   = 2 * DataWidth,
   parameter int TimeoutCycles = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_PORTS-1:0]           req_i,
   input  logic [DataWidth*NUM_PORTS-1:0] mult_a_i,
   input  logic [DataWidth*NUM_PORTS-1:0] mult_b_i,
   output logic [NUM_PORTS-1:0]           gnt_o,
   output logic [SEL_WIDTH-1:0]           sel_o,
   output logic [ResultWidth-1:0]         result_o,
   output logic                           overflow_o,
   output logic [NUM_PORTS-1:0]           result_valid_o,
   output logic                           error_o,
   output logic [DataWidth-1:0]           mult_a_o,
   output logic [DataWidth-1:0]           mult_b_o,
   output logic                           start_o,
   input  logic [ResultWidth-1:0]         value_i,
   input  logic                           overflow_i,
   input  logic                           done_i
);

   mult_arb_state_e state_q;
   mult_arb_state_e state_d;

   logic [SEL_WIDTH-1:0] rr_ptr_q;
   logic [SEL_WIDTH-1:0] next_ptr;
   logic [SEL_WIDTH-1:0] sel_q;

   logic [SEL_WIDTH-1:0] arb_idx;
   logic [NUM_PORTS-1:0] arb_gnt;
   logic                 arb_any;

   logic [DataWidth-1:0] a_sel;
   logic [DataWidth-1:0] b_sel;

   logic                 busy;
   logic                 capture;
   logic                 tmo;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr (
      .req (req_i),
      .ptr (rr_ptr_q),
      .idx (arb_idx),
      .gnt (arb_gnt),
      .any (arb_any)
   );

   // Operand mux driven by the one-hot pick, not by the index.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (arb_gnt[p]) begin
            a_sel = mult_a_i[p*DataWidth +: DataWidth];
            b_sel = mult_b_i[p*DataWidth +: DataWidth];
         end
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CntW = $clog2(TimeoutCycles + 1);

   logic [CntW-1:0] cnt_q;

   // Fires on the last allowed WAIT cycle so RESP follows immediately.
   assign tmo = (state_q == ST_WAIT) && !done_i &&
                (cnt_q == CntW'(TimeoutCycles - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (state_d == ST_ISSUE) begin
         cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   // No watchdog: WAIT holds until done. Always false for legal settings.
   assign tmo = (TimeoutCycles < 0);
`endif

   assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign capture = busy && done_i;

   assign next_ptr = (int'(sel_q) == NUM_PORTS - 1) ?
                     '0 : sel_q + 1'b1;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = done_i ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            if (done_i || tmo) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         sel_q          <= '0;
         mult_a_o       <= '0;
         mult_b_o       <= '0;
         start_o        <= 1'b0;
         result_o       <= '0;
         overflow_o     <= 1'b0;
         result_valid_o <= '0;
         error_o        <= 1'b0;
      end else begin
         state_q <= state_d;
         start_o <= (state_d == ST_ISSUE);
         error_o <= tmo;

         if (state_d == ST_RESP) begin
            result_valid_o <= NUM_PORTS'(1) << sel_q;
         end else begin
            result_valid_o <= '0;
         end

         if (state_q == ST_IDLE && arb_any) begin
            sel_q    <= arb_idx;
            mult_a_o <= a_sel;
            mult_b_o <= b_sel;
         end

         if (capture) begin
            result_o   <= value_i;
            overflow_o <= overflow_i;
         end else if (tmo) begin
            result_o   <= '0;
            overflow_o <= 1'b0;
         end

         if (state_q == ST_RESP) begin
            rr_ptr_q <= next_ptr;
         end
      end
   end

   // Grant is owned from ISSUE through RESP.
   assign gnt_o = (state_q == ST_IDLE) ? '0 : (NUM_PORTS'(1) << sel_q);
   assign sel_o = sel_q;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shared-multiplier arbiter: time-multiplexes one sequential multiplier among `NUM_PORTS` requesters with round-robin fairness. It latches the granted port's operands, issues a single-cycle start, waits for the multiplier's done, and returns the full-width result to the granted port with a one-cycle valid strobe. It sits between the layer compute units and the single multiplier instance, replacing the purely combinational operand mux with an owned, handshaked transaction.

## Interface
- `NUM_PORTS`, 6, number of requesting ports (≥1)
- `SEL_WIDTH`, `NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1`, grant index width
- `DataWidth`, 8, operand width
- `ResultWidth`, `2*DataWidth`, multiplier product width
- `TimeoutCycles`, 64, watchdog limit (used only with `MULT_ARB_TIMEOUT_EN`)

- `clk_i` in 1 — single clock, rising edge
- `rst_i` in 1 — asynchronous, active-high reset
- `req_i` in NUM_PORTS — per-port request, level
- `mult_a_i` in DataWidth*NUM_PORTS — packed operand A, port p at `[DataWidth*p +: DataWidth]`
- `mult_b_i` in DataWidth*NUM_PORTS — packed operand B, same packing
- `gnt_o` out NUM_PORTS — one-hot owner of the multiplier, high ISSUE through RESP
- `sel_o` out SEL_WIDTH — index of current/last granted port
- `result_o` out ResultWidth — product, held until next RESP
- `overflow_o` out 1 — registered `overflow_i` of last op
- `result_valid_o` out NUM_PORTS — one-hot, one cycle, in RESP
- `error_o` out 1 — timeout flag (constant 0 without macro)
- `mult_a_o`, `mult_b_o` out DataWidth — latched operands to multiplier
- `start_o` out 1 — one-cycle start pulse
- `value_i` in ResultWidth — multiplier product
- `overflow_i` in 1 — multiplier overflow
- `done_i` in 1 — multiplier completion strobe

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_i`, pick first set bit searching from `rr_ptr` upward with wrap; register index, one-hot grant, operands; go ISSUE. No req: stay.
- ISSUE: `start_o`=1 exactly one cycle. If `done_i` also high → RESP, else → WAIT.
- WAIT: hold; on `done_i` capture `value_i`/`overflow_i`, → RESP.
- RESP: `result_valid_o[sel]`=1 one cycle; `rr_ptr` ← (sel+1) mod NUM_PORTS; → IDLE.
- Operands are latched at grant; changes on `mult_*_i` or deassertion of `req_i` after grant are ignored; transaction always completes and result is still delivered.
- `done_i` in IDLE or RESP is ignored.
- Requester still asserting `req_i` after its RESP competes normally; ptr has moved past it, so other pending ports win first.
- NUM_PORTS=1: ptr fixed 0, arbitration trivial.
- Reset: state IDLE, `rr_ptr`=0, all outputs 0 (`gnt_o`, `sel_o`, `result_o`, `overflow_o`, `result_valid_o`, `error_o`, `mult_*_o`, `start_o`). Reset mid-transaction abandons it; no valid issued.

## Timing
- Req seen in IDLE at cycle t → `gnt_o`, `start_o` at t+1.
- `done_i` at cycle d (d ≥ t+1) → `result_valid_o`, `result_o` valid at d+1; IDLE at d+2.
- Minimum transaction: 3 cycles (IDLE→ISSUE→RESP) with same-cycle done; next grant no earlier than d+3.
- All outputs registered except `gnt_o`/`sel_o` decoded from registered state.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined: counter runs in WAIT; reaching `TimeoutCycles` without `done_i` → RESP with `result_o`=0, `overflow_o`=0, `error_o`=1 for that RESP cycle, `result_valid_o` still pulsed. Counter cleared on entry to ISSUE.
- Undefined: no counter, `error_o` tied 0, WAIT waits indefinitely.

## Structure
- `mult_arb_pkg`: state enum typedef `mult_arb_state_e`, state-width constant.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and `ptr`, outputs index and one-hot grant; pointer register stays in `mult_arbiter`.

## Test plan
- Single req: port 2 req, a=3, b=5, done 4 cycles after start → `start_o` one cycle, `result_valid_o`=6'b000100 with `result_o`=15, `overflow_o`=0.
- Fairness: ports 0,3,5 held high continuously → grant order 0,3,5,0 … ; no port granted twice while another pending.
- Same-cycle done: `done_i` asserted with `start_o` → RESP next cycle, 3-cycle transaction.
- Operand/req change after grant: port 1 a=7,b=9 granted, inputs changed to 0 and req dropped next cycle → result 63 delivered to port 1.
- Reset in WAIT: assert `rst_i` asynchronously → all outputs 0 immediately; later `done_i` ignored, no valid; next req of port 4 granted (ptr=0 search).
- Timeout (macro on, TimeoutCycles=8): no `done_i` → RESP after 8 WAIT cycles, `error_o`=1, `result_o`=0; macro off: stays WAIT.
